// File: rtl/lcd_text_writer.sv
// Purpose : 32-char frame buffer streamed to a 16x2 HD44780/OLED driver as 34 {rs,data} words.
// Latency : refresh_req -> first data_ready in 3 cycles once the driver is initialised and idle.
// Backpres: each word waits for lcd_busy to rise (ack) and then fall (done) before the next is loaded.
//
// Ports:
//   clk_i          system clock, all logic on posedge
//   reset_i        synchronous, active-high
//   wr_en_i        write wr_data_i into buffer[wr_addr_i] this cycle
//   wr_addr_i      buffer address 0..31 (row 0 = 0..15, row 1 = 16..31)
//   wr_data_i      ASCII character
//   refresh_req_i  one-cycle request to send the whole buffer
//   lcd_busy_i     driver busy_flag
//   d_out_o        {rs,data} to driver d_in
//   data_ready_o   one-cycle strobe to driver
//   active_o       high while a refresh pass is in progress
//   done_o         one-cycle pulse when a pass completes
module lcd_text_writer #(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter logic [7:0] ROW0_CMD  = 8'h80,
    parameter logic [7:0] ROW1_CMD  = 8'hC0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       wr_en_i,
    input  logic [4:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       refresh_req_i,
    input  logic       lcd_busy_i,
    output logic [8:0] d_out_o,
    output logic       data_ready_o,
    output logic       active_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'd33;

    state_t     state_q;
    logic [7:0] mem_q [32];
    logic [5:0] idx_q;
    logic       seen_busy_q;
    logic       init_done_q;
    logic       pending_q;
    logic       pending_d;
    logic [8:0] d_out_q;
    logic       data_ready_q;
    logic       active_q;
    logic       done_q;

    logic [4:0] rd_addr;
    logic [8:0] word_d;
    logic       launch;

    assign d_out_o      = d_out_q;
    assign data_ready_o = data_ready_q;
    assign active_o     = active_q;
    assign done_o       = done_q;

    // Word for the current index. Row 1 data sits two words after its buffer
    // address (two command words precede it); the 5-bit subtraction wraps
    // idx 33 onto address 31 as required.
    always_comb begin
        rd_addr = 5'd0;
        word_d  = 9'd0;
        if (idx_q == 6'd0) begin
            word_d = {1'b0, ROW0_CMD};
        end else if (idx_q <= 6'd16) begin
            rd_addr = idx_q[4:0] - 5'd1;
            word_d  = {1'b1, mem_q[rd_addr]};
        end else if (idx_q == 6'd17) begin
            word_d = {1'b0, ROW1_CMD};
        end else begin
            rd_addr = idx_q[4:0] - 5'd2;
            word_d  = {1'b1, mem_q[rd_addr]};
        end
    end

    assign launch = (state_q == S_IDLE) && pending_q && init_done_q && !lcd_busy_i;

    // A request arriving in the launch cycle is folded into the pass that is
    // starting: nothing has been read from the buffer yet.
    always_comb begin
        pending_d = pending_q | refresh_req_i;
        if (launch) begin
            pending_d = 1'b0;
        end
    end

    // Frame buffer. The LOAD read above sees the pre-write value when a write
    // hits the same address in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= FILL_CHAR;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            idx_q        <= 6'd0;
            seen_busy_q  <= 1'b0;
            init_done_q  <= 1'b0;
            pending_q    <= 1'b0;
            d_out_q      <= 9'd0;
            data_ready_q <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            done_q       <= 1'b0;
            pending_q    <= pending_d;
            // Driver is considered initialised once its power-on busy period
            // has been observed to end.
            seen_busy_q  <= seen_busy_q | lcd_busy_i;
            init_done_q  <= init_done_q | (seen_busy_q & ~lcd_busy_i);

            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        idx_q    <= 6'd0;
                        active_q <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    d_out_q      <= word_d;
                    data_ready_q <= 1'b1;
                    state_q      <= S_ISSUE;
                end
                S_ISSUE: begin
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (lcd_busy_i) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!lcd_busy_i) begin
                        if (idx_q == LAST_IDX) begin
                            done_q   <= 1'b1;
                            active_q <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 6'd1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_writer.sv
module tb_lcd_text_writer;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       wr_en_i;
    logic [4:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       refresh_req_i;
    logic       lcd_busy_i;
    logic [8:0] d_out_o;
    logic       data_ready_o;
    logic       active_o;
    logic       done_o;

    always #5 clk_i = ~clk_i;

    lcd_text_writer dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .refresh_req_i (refresh_req_i),
        .lcd_busy_i    (lcd_busy_i),
        .d_out_o       (d_out_o),
        .data_ready_o  (data_ready_o),
        .active_o      (active_o),
        .done_o        (done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: what the display should hold, and the words a pass must emit.
    logic [7:0] ref_mem [32];
    logic [8:0] exp_q [$];

    // Observations from the driver model (written only by the monitor).
    logic [8:0] words [$];
    int         strobe_cyc [$];
    int         done_cyc [$];
    int         cyc      = 0;
    int         dr_total = 0;
    int         dones    = 0;
    int         mdl_phase = 0;
    int         mdl_cnt   = 0;
    logic [8:0] hold_val  = 9'd0;
    int         stab_err  = 0;
    int         gap_err   = 0;
    logic       model_busy = 1'b0;

    // Controls from the test tasks.
    bit         model_en  = 1'b0;
    logic       por_busy  = 1'b0;
    int         ack_delay = 0;
    int         busy_len  = 4;

    assign lcd_busy_i = por_busy | model_busy;

    // LCD driver model: on each strobe, record the word, raise busy after
    // ack_delay cycles, hold it busy_len cycles, and require d_out stable until
    // busy is released.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (done_o === 1'b1) begin
                dones++;
                done_cyc.push_back(cyc);
            end
            if (data_ready_o === 1'b1) begin
                dr_total++;
                strobe_cyc.push_back(cyc);
            end
            if (!model_en) begin
                mdl_phase  = 0;
                model_busy = 1'b0;
            end else if (data_ready_o === 1'b1) begin
                if (mdl_phase != 0) gap_err++;
                words.push_back(d_out_o);
                hold_val  = d_out_o;
                mdl_phase = 1;
                mdl_cnt   = ack_delay;
            end else if (mdl_phase == 1) begin
                if (d_out_o !== hold_val) stab_err++;
                if (mdl_cnt == 0) begin
                    model_busy = 1'b1;
                    mdl_phase  = 2;
                    mdl_cnt    = busy_len;
                end else begin
                    mdl_cnt--;
                end
            end else if (mdl_phase == 2) begin
                if (d_out_o !== hold_val) stab_err++;
                if (mdl_cnt == 0) begin
                    model_busy = 1'b0;
                    mdl_phase  = 0;
                end else begin
                    mdl_cnt--;
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset_i       = 1'b1;
        wr_en_i       = 1'b0;
        refresh_req_i = 1'b0;
        model_en      = 1'b0;
        por_busy      = 1'b0;
        tick(3);
        reset_i = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h20;
        tick(1);
    endtask

    task automatic power_on(input int n);
        por_busy = 1'b1;
        tick(n);
        por_busy = 1'b0;
        model_en = 1'b1;
        tick(2);
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        tick(1);
        wr_en_i    = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic random_writes(input int n);
        for (int k = 0; k < n; k++) begin
            write_char(5'($urandom_range(31)), 8'($urandom_range(255)));
        end
    endtask

    task automatic pulse_refresh();
        refresh_req_i = 1'b1;
        tick(1);
        refresh_req_i = 1'b0;
    endtask

    // One pass as the display expects it: row-0 address command, 16 chars,
    // row-1 address command, 16 chars.
    task automatic build_pass(input logic [7:0] m [32]);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, m[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, m[i]});
    endtask

    task automatic wait_passes(input int dbase, input int n, output bit timed_out);
        int budget;
        budget = 20000;
        while (((dones - dbase) < n || mdl_phase != 0) && budget > 0) begin
            tick(1);
            budget--;
        end
        timed_out = (budget == 0);
        tick(10);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick(2);
        n_checks++;
        if (d_out_o !== 9'd0) begin
            n_fail++; $display("FAIL reset_d_out: got 0x%03h required 0x000", d_out_o);
        end
        n_checks++;
        if (data_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_data_ready: got %b required 0", data_ready_o);
        end
        n_checks++;
        if (active_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_active: got %b required 0", active_o);
        end
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b required 0", done_o);
        end
        apply_reset();
    endtask

    task automatic test_blank_pass();
        int wbase, dbase;
        bit to;
        power_on(100);
        exp_q.delete();
        build_pass(ref_mem);
        wbase = words.size();
        dbase = dones;
        pulse_refresh();
        wait_passes(dbase, 1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL blank_timeout: dones %0d required 1", dones - dbase); end
        n_checks++;
        if ((words.size() - wbase) !== exp_q.size()) begin
            n_fail++; $display("FAIL blank_count: got %0d required %0d", words.size() - wbase, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wbase + i < words.size()) begin
                n_checks++;
                if (words[wbase + i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL blank_word[%0d]: got 0x%03h required 0x%03h", i, words[wbase + i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if ((dones - dbase) !== 1) begin n_fail++; $display("FAIL blank_done_pulses: got %0d required 1", dones - dbase); end
        n_checks++;
        if (active_o !== 1'b0) begin n_fail++; $display("FAIL blank_active_after: got %b required 0", active_o); end
    endtask

    task automatic test_content(input int nwr, input logic [7:0] a0, input logic [7:0] a17);
        int wbase, dbase;
        bit to;
        if (nwr == 0) begin
            write_char(5'd0, a0);
            write_char(5'd17, a17);
        end else begin
            random_writes(nwr);
        end
        exp_q.delete();
        build_pass(ref_mem);
        wbase = words.size();
        dbase = dones;
        pulse_refresh();
        wait_passes(dbase, 1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL content_timeout: dones %0d required 1", dones - dbase); end
        n_checks++;
        if ((words.size() - wbase) !== exp_q.size()) begin
            n_fail++; $display("FAIL content_count: got %0d required %0d", words.size() - wbase, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wbase + i < words.size()) begin
                n_checks++;
                if (words[wbase + i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL content_word[%0d]: got 0x%03h required 0x%03h", i, words[wbase + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_directed_writes();
        test_content(0, 8'h48, 8'h69);
    endtask

    task automatic test_random_content();
        for (int r = 0; r < 2; r++) test_content(24, 8'h00, 8'h00);
    endtask

    task automatic test_back_to_back();
        int wbase, dbase, sbase, dcbase, gbase, budget;
        logic [7:0] old2;
        logic [7:0] p1 [32];
        bit to;
        wbase  = words.size();
        dbase  = dones;
        sbase  = strobe_cyc.size();
        dcbase = done_cyc.size();
        gbase  = gap_err;
        pulse_refresh();
        budget = 5000;
        while ((words.size() - wbase) < 10 && budget > 0) begin
            tick(1);
            budget--;
        end
        n_checks++;
        if (budget == 0) begin n_fail++; $display("FAIL b2b_reach_idx10: got %0d words required 10", words.size() - wbase); end
        // addr 2 is already sent this pass, addr 20 is not yet sent
        old2 = ref_mem[2];
        write_char(5'd2, ref_mem[2] + 8'd1);
        write_char(5'd20, ref_mem[20] + 8'd3);
        pulse_refresh();
        tick(1);
        pulse_refresh();
        p1 = ref_mem;
        p1[2] = old2;
        exp_q.delete();
        build_pass(p1);
        build_pass(ref_mem);
        wait_passes(dbase, 2, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL b2b_timeout: dones %0d required 2", dones - dbase); end
        n_checks++;
        if ((words.size() - wbase) !== exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d required %0d", words.size() - wbase, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wbase + i < words.size()) begin
                n_checks++;
                if (words[wbase + i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL b2b_word[%0d]: got 0x%03h required 0x%03h", i, words[wbase + i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if ((dones - dbase) !== 2) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d required 2", dones - dbase); end
        if (strobe_cyc.size() > sbase + 34 && done_cyc.size() > dcbase) begin
            n_checks++;
            if ((strobe_cyc[sbase + 34] - done_cyc[dcbase]) > 3) begin
                n_fail++; $display("FAIL b2b_restart_gap: got %0d cycles required <= 3", strobe_cyc[sbase + 34] - done_cyc[dcbase]);
            end
        end
        n_checks++;
        if ((gap_err - gbase) !== 0) begin n_fail++; $display("FAIL b2b_strobe_while_busy: got %0d required 0", gap_err - gbase); end
    endtask

    task automatic test_busy_at_init();
        int wbase, dbase, drbase;
        bit to;
        apply_reset();
        drbase = dr_total;
        pulse_refresh();
        tick(30);
        por_busy = 1'b1;
        tick(5);
        pulse_refresh();
        tick(40);
        n_checks++;
        if ((dr_total - drbase) !== 0) begin n_fail++; $display("FAIL init_no_strobe: got %0d strobes required 0", dr_total - drbase); end
        n_checks++;
        if (active_o !== 1'b0) begin n_fail++; $display("FAIL init_active: got %b required 0", active_o); end
        exp_q.delete();
        build_pass(ref_mem);
        wbase = words.size();
        dbase = dones;
        model_en = 1'b1;
        por_busy = 1'b0;
        wait_passes(dbase, 1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL init_timeout: dones %0d required 1", dones - dbase); end
        n_checks++;
        if ((words.size() - wbase) !== exp_q.size()) begin
            n_fail++; $display("FAIL init_count: got %0d required %0d", words.size() - wbase, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wbase + i < words.size()) begin
                n_checks++;
                if (words[wbase + i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL init_word[%0d]: got 0x%03h required 0x%03h", i, words[wbase + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        int wbase, dbase, drbase, budget;
        bit to;
        random_writes(10);
        wbase = words.size();
        pulse_refresh();
        budget = 5000;
        while ((words.size() - wbase) < 20 && budget > 0) begin
            tick(1);
            budget--;
        end
        n_checks++;
        if (budget == 0) begin n_fail++; $display("FAIL rst_reach_idx20: got %0d words required 20", words.size() - wbase); end
        reset_i  = 1'b1;
        model_en = 1'b0;
        tick(1);
        n_checks++;
        if (data_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data_ready: got %b required 0", data_ready_o); end
        n_checks++;
        if (active_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_active: got %b required 0", active_o); end
        n_checks++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b required 0", done_o); end
        tick(2);
        drbase  = dr_total;
        reset_i = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h20;
        tick(60);
        power_on(20);
        tick(40);
        n_checks++;
        if ((dr_total - drbase) !== 0) begin n_fail++; $display("FAIL rst_mid_no_strobe: got %0d strobes required 0", dr_total - drbase); end
        exp_q.delete();
        build_pass(ref_mem);
        wbase = words.size();
        dbase = dones;
        pulse_refresh();
        wait_passes(dbase, 1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rst_timeout: dones %0d required 1", dones - dbase); end
        n_checks++;
        if ((words.size() - wbase) !== exp_q.size()) begin
            n_fail++; $display("FAIL rst_count: got %0d required %0d", words.size() - wbase, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wbase + i < words.size()) begin
                n_checks++;
                if (words[wbase + i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rst_word[%0d]: got 0x%03h required 0x%03h", i, words[wbase + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_slow_lcd();
        int wbase, dbase, drbase, sbase, gbase;
        bit to;
        ack_delay = 3;
        busy_len  = 50;
        random_writes(8);
        exp_q.delete();
        build_pass(ref_mem);
        wbase  = words.size();
        dbase  = dones;
        drbase = dr_total;
        sbase  = stab_err;
        gbase  = gap_err;
        pulse_refresh();
        wait_passes(dbase, 1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL slow_timeout: dones %0d required 1", dones - dbase); end
        n_checks++;
        if ((dr_total - drbase) !== 34) begin n_fail++; $display("FAIL slow_strobes: got %0d required 34", dr_total - drbase); end
        n_checks++;
        if ((stab_err - sbase) !== 0) begin n_fail++; $display("FAIL slow_d_out_stable: got %0d changes required 0", stab_err - sbase); end
        n_checks++;
        if ((gap_err - gbase) !== 0) begin n_fail++; $display("FAIL slow_strobe_while_busy: got %0d required 0", gap_err - gbase); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wbase + i < words.size()) begin
                n_checks++;
                if (words[wbase + i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL slow_word[%0d]: got 0x%03h required 0x%03h", i, words[wbase + i], exp_q[i]);
                end
            end
        end
        ack_delay = 0;
        busy_len  = 4;
    endtask

    initial begin
        reset_i       = 1'b1;
        wr_en_i       = 1'b0;
        wr_addr_i     = 5'd0;
        wr_data_i     = 8'd0;
        refresh_req_i = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h20;
        test_reset();
        test_blank_pass();
        test_directed_writes();
        test_random_content();
        test_back_to_back();
        test_busy_at_init();
        test_reset_mid_pass();
        test_slow_lcd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
